// File: rtl/sub16_ns_pkg.sv
// Shared definitions for the nibble-serial 16-bit subtractor: widths, FSM states and the
// nibble-select helper used to feed the 4-bit adder.
package sub16_ns_pkg;

  localparam int unsigned Width   = 16;
  localparam int unsigned Nibbles = 4;
  localparam logic [1:0]  LastIdx = 2'(Nibbles - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [3:0] nib_sel(input logic [Width-1:0] v, input logic [1:0] idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sub16_ns_cla4.sv
// 4-bit carry-lookahead adder: s = a + b + ci, with flattened lookahead carries.
module sub16_ns_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = ci_i;
  assign c[1] = g[0] | (p[0] & ci_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci_i);

  assign s_o  = p ^ c[3:0];
  assign co_o = c[4];

endmodule

// File: rtl/sub16_ns.sv
// Nibble-serial 16-bit subtractor: d = a - b computed as a + ~b + 1, one nibble per cycle
// through a single cla4, with borrow/zero/signed-overflow flags and a start/done handshake.
module sub16_ns
  import sub16_ns_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] d,
  output logic             borrow,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [Width-1:0] opa_q, opa_d;
  logic [Width-1:0] opb_q, opb_d;   // holds ~b
  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] d_q, d_d;
  logic             carry_q, carry_d;
  logic [1:0]       idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       cla_s;
  logic             cla_co;

  sub16_ns_cla4 u_cla4 (
    .a_i  (nib_sel(opa_q, idx_q)),
    .b_i  (nib_sel(opb_q, idx_q)),
    .ci_i (carry_q),
    .s_o  (cla_s),
    .co_o (cla_co)
  );

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          opa_d   = a;
          opb_d   = ~b;
          carry_d = 1'b1;
          idx_d   = 2'd0;
        end
      end
      StRun: begin
        acc_d[{idx_q, 2'b00} +: 4] = cla_s;
        carry_d = cla_co;
        idx_d   = idx_q + 2'd1;
        // Results become visible only once the last nibble lands.
        if (idx_q == LastIdx) begin
          state_d  = StDone;
          d_d      = acc_d;
          borrow_d = ~cla_co;
          zero_d   = (acc_d == '0);
          ovf_d    = (opa_q[Width-1] == opb_q[Width-1]) && (acc_d[Width-1] != opa_q[Width-1]);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= 2'd0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign d      = d_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_sub16_ns.sv
// Self-checking bench for sub16_ns: directed and random subtractions against an arithmetic
// reference, held-start back-to-back behaviour and mid-operation reset.
module tb_sub16_ns;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] d;
  logic        borrow;
  logic        zero;
  logic        ovf;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  sub16_ns dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .d       (d),
    .borrow  (borrow),
    .zero    (zero),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {borrow, zero, ovf, d} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
    int          ud;
    int          sd;
    logic [15:0] dd;
    ud = int'(x) - int'(y);
    sd = int'($signed(x)) - int'($signed(y));
    dd = ud[15:0];
    return {ud < 0, dd == 16'h0000, (sd > 32767) || (sd < -32768), dd};
  endfunction

  // Runs one operation from idle; operands are scrambled every cycle after the accept edge.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                       output logic [18:0] obs, output int lat,
                       output logic busy_held, output logic after_idle);
    a = ta;
    b = tb_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_held = busy;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      busy_held = busy_held & busy;
      if (done) begin
        lat = i;
        break;
      end
    end
    obs = {borrow, zero, ovf, d};
    tick();
    after_idle = !busy && !done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    repeat (2) tick();
    total++;
    if ({borrow, zero, ovf, d} !== 19'h0) begin
      bad++;
      $display("FAIL reset_result: got %h want 0", {borrow, zero, ovf, d});
    end
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ctrl: busy/done got %b want 00", {busy, done});
    end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic check_op(input string name, input logic [15:0] x, input logic [15:0] y);
    logic [18:0] obs;
    logic [18:0] exp_v;
    int          lat;
    logic        held;
    logic        idle;
    exp_v = model(x, y);
    do_op(x, y, obs, lat, held, idle);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s_result: a=%h b=%h got {bo,z,ov,d}=%h want %h", name, x, y, obs, exp_v);
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL %s_latency: got %0d want 4", name, lat);
    end
    total++;
    if ({held, idle} !== 2'b11) begin
      bad++;
      $display("FAIL %s_busy: busy_held/idle_after got %b want 11", name, {held, idle});
    end
  endtask

  task automatic test_directed();
    check_op("plain", 16'h1234, 16'h0234);
    check_op("ripple", 16'h0000, 16'h0001);
    check_op("ovf_neg", 16'h8000, 16'h0001);
    check_op("ovf_pos", 16'h7FFF, 16'hFFFF);
    check_op("equal", 16'hABCD, 16'hABCD);
  endtask

  task automatic test_random();
    logic [15:0] x;
    logic [15:0] y;
    for (int n = 0; n < 25; n++) begin
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x ^ 16'h8000;
        default: y = 16'($urandom);
      endcase
      check_op("random", x, y);
    end
  endtask

  // Start held high with fresh operands every cycle; only idle-time accepts take effect.
  task automatic test_back_to_back();
    int          acc_k[$];
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          free_at;
    int          done_cnt;
    int          hit;
    logic        exp_busy;
    logic        exp_done;
    logic [18:0] exp_v;
    free_at = 0;
    done_cnt = 0;
    for (int k = 0; k < 18; k++) begin
      start = (k < 10);
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      if (start && k >= free_at) begin
        acc_k.push_back(k);
        qa.push_back(a);
        qb.push_back(b);
        free_at = k + 6;
      end
      exp_busy = 1'b0;
      exp_done = 1'b0;
      hit = -1;
      for (int j = 0; j < acc_k.size(); j++) begin
        if (k >= acc_k[j] && k <= acc_k[j] + 4) exp_busy = 1'b1;
        if (k == acc_k[j] + 4) begin
          exp_done = 1'b1;
          hit = j;
        end
      end
      if (done) done_cnt++;
      total++;
      if ({busy, done} !== {exp_busy, exp_done}) begin
        bad++;
        $display("FAIL b2b_ctrl: cycle %0d busy/done got %b want %b", k, {busy, done},
                 {exp_busy, exp_done});
      end
      if (hit >= 0) begin
        exp_v = model(qa[hit], qb[hit]);
        total++;
        if ({borrow, zero, ovf, d} !== exp_v) begin
          bad++;
          $display("FAIL b2b_result: cycle %0d got %h want %h", k, {borrow, zero, ovf, d}, exp_v);
        end
      end
    end
    start = 1'b0;
    total++;
    if (done_cnt !== 2) begin
      bad++;
      $display("FAIL b2b_count: done pulses got %0d want 2", done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [18:0] obs;
    int          lat;
    logic        held;
    logic        idle;
    do_op(16'h9F31, 16'h0102, obs, lat, held, idle);
    a = 16'h1234;
    b = 16'h0FFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy, done, borrow, zero, ovf, d} !== 21'h0) begin
      bad++;
      $display("FAIL midreset_clear: got %h want 0", {busy, done, borrow, zero, ovf, d});
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_idle: busy got %b want 0", busy);
    end
    do_op(16'h0010, 16'h0001, obs, lat, held, idle);
    total++;
    if (obs !== {3'b000, 16'h000F}) begin
      bad++;
      $display("FAIL midreset_next: got %h want %h", obs, {3'b000, 16'h000F});
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL midreset_latency: got %0d want 4", lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
